// File: rtl/ws2812_serializer_if.sv
// Byte-pull handshake between the colour fader (master) and the WS2812 line driver (slave).
interface ws2812_serializer_if;
    logic       trigger;
    logic [7:0] color_now;
    logic       data_request;

    modport master (output trigger, output color_now, input data_request);
    modport slave  (input trigger, input color_now, output data_request);
endinterface

// File: rtl/ws2812_serializer.sv
// WS2812 line driver: pulls LEDS*3 bytes per frame and emits MSB-first NRZ pulse-width bit cells,
// followed by a forced-low latch gap.
module ws2812_serializer #(
    parameter int LEDS   = 32,
    parameter int T0H    = 4,
    parameter int T1H    = 8,
    parameter int TBIT   = 15,
    parameter int TRESET = 3600
) (
    input  logic                 clk,
    input  logic                 rst,
    ws2812_serializer_if.slave   bus,
    output logic                 dout,
    output logic                 busy
);
    localparam int NBYTES = LEDS * 3;
    localparam int BCW    = $clog2(NBYTES + 1);
    localparam int BTW    = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam int RCW    = (TRESET > 1) ? $clog2(TRESET) : 1;

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES);
    localparam logic [BTW-1:0] BIT_END   = BTW'(TBIT - 1);
    localparam logic [BTW-1:0] HIGH_ZERO = BTW'(T0H);
    localparam logic [BTW-1:0] HIGH_ONE  = BTW'(T1H);
    localparam logic [RCW-1:0] GAP_END   = RCW'(TRESET - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BIT   = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [7:0]     shift_r, shift_s;
    logic [BCW-1:0] byte_cnt_r, byte_cnt_s;
    logic [2:0]     bit_idx_r, bit_idx_s;
    logic [BTW-1:0] bit_cnt_r, bit_cnt_s;
    logic [RCW-1:0] reset_cnt_r, reset_cnt_s;
    logic           dout_r, busy_r;
    logic           req_s, line_s;

    // Next-state, byte fetch strobe and raw line level.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        byte_cnt_s  = byte_cnt_r;
        bit_idx_s   = bit_idx_r;
        bit_cnt_s   = bit_cnt_r;
        reset_cnt_s = reset_cnt_r;
        req_s       = 1'b0;
        line_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.trigger) begin
                    req_s      = 1'b1;
                    shift_s    = bus.color_now;
                    byte_cnt_s = BCW'(1);
                    bit_idx_s  = 3'd7;
                    bit_cnt_s  = {BTW{1'b0}};
                    state_s    = BIT;
                end else begin
                    state_s = IDLE;
                end
            end
            BIT: begin
                line_s = (bit_cnt_r < (shift_r[7] ? HIGH_ONE : HIGH_ZERO));
                if (bit_cnt_r == BIT_END) begin
                    bit_cnt_s = {BTW{1'b0}};
                    if (bit_idx_r != 3'd0) begin
                        shift_s   = {shift_r[6:0], 1'b0};
                        bit_idx_s = bit_idx_r - 3'd1;
                    end else if (byte_cnt_r < LAST_BYTE) begin
                        // Next byte is fetched in the last cycle of the current one so cells stay gapless.
                        req_s      = 1'b1;
                        shift_s    = bus.color_now;
                        byte_cnt_s = byte_cnt_r + BCW'(1);
                        bit_idx_s  = 3'd7;
                    end else begin
                        reset_cnt_s = {RCW{1'b0}};
                        state_s     = LATCH;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + BTW'(1);
                end
            end
            LATCH: begin
                if (reset_cnt_r == GAP_END) begin
                    state_s = IDLE;
                end else begin
                    reset_cnt_s = reset_cnt_r + RCW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; the line is re-timed through a flop to stay glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            shift_r     <= 8'd0;
            byte_cnt_r  <= {BCW{1'b0}};
            bit_idx_r   <= 3'd0;
            bit_cnt_r   <= {BTW{1'b0}};
            reset_cnt_r <= {RCW{1'b0}};
            dout_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            byte_cnt_r  <= byte_cnt_s;
            bit_idx_r   <= bit_idx_s;
            bit_cnt_r   <= bit_cnt_s;
            reset_cnt_r <= reset_cnt_s;
            dout_r      <= line_s;
            busy_r      <= (state_s != IDLE);
        end
    end

    assign bus.data_request = req_s;
    assign dout             = dout_r;
    assign busy             = busy_r;
endmodule

// File: tb/tb_ws2812_serializer.sv
// Bench for ws2812_serializer: three parameter sets checked cycle-by-cycle against an arithmetic waveform model.
module tb_ws2812_serializer;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   sel;
    logic obs_dout, obs_busy, obs_req;
    logic dout0, dout1, dout2, busy0, busy1, busy2;
    logic [7:0] frame_bytes [0:95];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ws2812_serializer_if bus0();
    ws2812_serializer_if bus1();
    ws2812_serializer_if bus2();

    ws2812_serializer #(.LEDS(1)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave), .dout(dout0), .busy(busy0));
    ws2812_serializer #(.LEDS(32)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave), .dout(dout1), .busy(busy1));
    ws2812_serializer #(.LEDS(2), .T0H(1), .T1H(2), .TBIT(3), .TRESET(1)) u2
        (.clk(clk), .rst(rst), .bus(bus2.slave), .dout(dout2), .busy(busy2));

    always_comb begin
        case (sel)
            0:       begin obs_dout = dout0; obs_busy = busy0; obs_req = bus0.data_request; end
            1:       begin obs_dout = dout1; obs_busy = busy1; obs_req = bus1.data_request; end
            default: begin obs_dout = dout2; obs_busy = busy2; obs_req = bus2.data_request; end
        endcase
    end

    function automatic int p_leds(input int s);   return (s == 0) ? 1 : ((s == 1) ? 32 : 2); endfunction
    function automatic int p_t0h(input int s);    return (s == 2) ? 1 : 4;    endfunction
    function automatic int p_t1h(input int s);    return (s == 2) ? 2 : 8;    endfunction
    function automatic int p_tbit(input int s);   return (s == 2) ? 3 : 15;   endfunction
    function automatic int p_treset(input int s); return (s == 2) ? 1 : 3600; endfunction

    // Expected dout at cycle t of a frame (t=0 is the IDLE cycle that takes the first byte).
    function automatic logic exp_dout(input int s, input int t);
        int tb_len;
        int nbits;
        int k;
        int c;
        logic [7:0] by;
        tb_len = p_tbit(s);
        nbits  = p_leds(s) * 24;
        if (t < 2 || (t - 2) >= nbits * tb_len) return 1'b0;
        k  = (t - 2) / tb_len;
        c  = (t - 2) % tb_len;
        by = frame_bytes[k / 8];
        return (c < (by[7 - (k % 8)] ? p_t1h(s) : p_t0h(s))) ? 1'b1 : 1'b0;
    endfunction

    task automatic drive(input int s, input logic tg, input logic [7:0] cv);
        bus0.trigger   = (s == 0) ? tg : 1'b0;
        bus1.trigger   = (s == 1) ? tg : 1'b0;
        bus2.trigger   = (s == 2) ? tg : 1'b0;
        bus0.color_now = cv;
        bus1.color_now = cv;
        bus2.color_now = cv;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) frame_bytes[i] = 8'($urandom);
    endtask

    // mode: 0 = trigger pulsed once, 1 = held high, 2 = random while busy.
    task automatic run_frame(input int s, input int limit, input int mode,
                             output int bd, output int bb, output int br,
                             output int nreq, output int rise);
        int t_bit;
        int flen;
        int n;
        logic er;
        logic tg;
        logic [7:0] cv;
        t_bit = p_tbit(s);
        flen  = p_leds(s) * 24 * t_bit + p_treset(s) + 1;
        n     = (limit < flen) ? limit : flen;
        bd = 0; bb = 0; br = 0; nreq = 0; rise = -1;
        sel = s;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            er = ((t % (8 * t_bit)) == 0) && ((t / (8 * t_bit)) < p_leds(s) * 3);
            cv = er ? frame_bytes[t / (8 * t_bit)] : 8'($urandom);
            if (t == 0)         tg = 1'b1;
            else if (mode == 0) tg = 1'b0;
            else if (mode == 1) tg = 1'b1;
            else                tg = 1'($urandom);
            drive(s, tg, cv);
            #1;
            if (obs_dout !== exp_dout(s, t)) bd++;
            if (obs_busy !== ((t >= 1) ? 1'b1 : 1'b0)) bb++;
            if (obs_req !== er) br++;
            if (obs_req === 1'b1) nreq++;
            if (obs_dout === 1'b1 && rise < 0) rise = t;
        end
    endtask

    task automatic idle_count(input int s, input int n, output int cnt);
        cnt = 0;
        sel = s;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(s, 1'b0, 8'($urandom));
            #1;
            if ({obs_dout, obs_busy, obs_req} !== 3'b000) cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            total++;
            if ({obs_dout, obs_busy, obs_req} !== 3'b000) begin
                bad++;
                $display("FAIL reset_state inst=%0d got dout/busy/req=%b want 000", s, {obs_dout, obs_busy, obs_req});
            end
        end
    endtask

    task automatic test_pattern();
        int bd, bb, br, nreq, rise, ic;
        frame_bytes[0] = 8'hA5;
        frame_bytes[1] = 8'h00;
        frame_bytes[2] = 8'hFF;
        run_frame(0, 1000000, 0, bd, bb, br, nreq, rise);
        total++; if (bd !== 0)   begin bad++; $display("FAIL pattern_dout bad_cycles=%0d want 0", bd); end
        total++; if (bb !== 0)   begin bad++; $display("FAIL pattern_busy bad_cycles=%0d want 0", bb); end
        total++; if (br !== 0)   begin bad++; $display("FAIL pattern_req bad_cycles=%0d want 0", br); end
        total++; if (nreq !== 3) begin bad++; $display("FAIL pattern_req_count got=%0d want 3", nreq); end
        total++; if (rise !== 2) begin bad++; $display("FAIL pattern_first_rise got=%0d want 2", rise); end
        idle_count(0, 5, ic);
        total++; if (ic !== 0)   begin bad++; $display("FAIL pattern_idle_after bad_cycles=%0d want 0", ic); end
    endtask

    task automatic test_back_to_back();
        int bd, bb, br, nreq, rise, ic;
        for (int f = 0; f < 2; f++) begin
            fill_random(96);
            run_frame(1, 1000000, 1, bd, bb, br, nreq, rise);
            total++; if (bd !== 0)    begin bad++; $display("FAIL b2b_dout frame=%0d bad_cycles=%0d want 0", f, bd); end
            total++; if (bb !== 0)    begin bad++; $display("FAIL b2b_busy frame=%0d bad_cycles=%0d want 0", f, bb); end
            total++; if (br !== 0)    begin bad++; $display("FAIL b2b_req frame=%0d bad_cycles=%0d want 0", f, br); end
            total++; if (nreq !== 96) begin bad++; $display("FAIL b2b_req_count frame=%0d got=%0d want 96", f, nreq); end
            total++; if (rise !== 2)  begin bad++; $display("FAIL b2b_first_rise frame=%0d got=%0d want 2", f, rise); end
        end
        idle_count(1, 4, ic);
        total++; if (ic !== 0) begin bad++; $display("FAIL b2b_idle_after bad_cycles=%0d want 0", ic); end
    endtask

    task automatic test_trigger_toggle();
        int bd, bb, br, nreq, rise, ic;
        for (int f = 0; f < 2; f++) begin
            fill_random(3);
            run_frame(0, 1000000, 2, bd, bb, br, nreq, rise);
            total++; if (bd !== 0)   begin bad++; $display("FAIL toggle_dout frame=%0d bad_cycles=%0d want 0", f, bd); end
            total++; if (br !== 0)   begin bad++; $display("FAIL toggle_req frame=%0d bad_cycles=%0d want 0", f, br); end
            total++; if (nreq !== 3) begin bad++; $display("FAIL toggle_req_count frame=%0d got=%0d want 3", f, nreq); end
        end
        idle_count(0, 3, ic);
        total++; if (ic !== 0) begin bad++; $display("FAIL toggle_idle_after bad_cycles=%0d want 0", ic); end
    endtask

    task automatic test_reset_midframe();
        int bd, bb, br, nreq, rise, ic, cut;
        fill_random(96);
        cut = 1 + 9 * 8 * p_tbit(1) + 49;
        run_frame(1, cut, 1, bd, bb, br, nreq, rise);
        total++; if (bd !== 0) begin bad++; $display("FAIL midrst_pre_dout bad_cycles=%0d want 0", bd); end
        total++; if (nreq !== 10) begin bad++; $display("FAIL midrst_pre_req_count got=%0d want 10", nreq); end
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1'b0, 8'($urandom));
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({obs_dout, obs_busy, obs_req} !== 3'b000) begin
            bad++;
            $display("FAIL midrst_after got dout/busy/req=%b want 000", {obs_dout, obs_busy, obs_req});
        end
        fill_random(96);
        run_frame(1, 1000000, 0, bd, bb, br, nreq, rise);
        total++; if (bd !== 0)    begin bad++; $display("FAIL midrst_restart_dout bad_cycles=%0d want 0", bd); end
        total++; if (bb !== 0)    begin bad++; $display("FAIL midrst_restart_busy bad_cycles=%0d want 0", bb); end
        total++; if (nreq !== 96) begin bad++; $display("FAIL midrst_restart_req_count got=%0d want 96", nreq); end
        idle_count(1, 3, ic);
        total++; if (ic !== 0) begin bad++; $display("FAIL midrst_idle_after bad_cycles=%0d want 0", ic); end
    endtask

    task automatic test_edge_params();
        int bd, bb, br, nreq, rise, ic;
        for (int f = 0; f < 3; f++) begin
            fill_random(6);
            run_frame(2, 1000000, 1, bd, bb, br, nreq, rise);
            total++; if (bd !== 0)   begin bad++; $display("FAIL edge_dout frame=%0d bad_cycles=%0d want 0", f, bd); end
            total++; if (bb !== 0)   begin bad++; $display("FAIL edge_busy frame=%0d bad_cycles=%0d want 0", f, bb); end
            total++; if (br !== 0)   begin bad++; $display("FAIL edge_req frame=%0d bad_cycles=%0d want 0", f, br); end
            total++; if (nreq !== 6) begin bad++; $display("FAIL edge_req_count frame=%0d got=%0d want 6", f, nreq); end
        end
        idle_count(2, 3, ic);
        total++; if (ic !== 0) begin bad++; $display("FAIL edge_idle_after bad_cycles=%0d want 0", ic); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sel   = 0;
        test_reset();
        test_pattern();
        test_trigger_toggle();
        test_edge_params();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
